// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a byte on tx_start and shifts it out LSB-first as start/data/[parity]/stop.
// tx_busy is high for the whole frame; tx_end pulses for one cycle when the last stop bit completes.
module uart_tx_serializer #(
   parameter int DIV_RATE   = 260,
   parameter int DIV_CNT_W  = 9,
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_busy,
   output logic              tx_end,
   output logic              tx
);
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_n;
   logic [DIV_CNT_W-1:0] div_cnt, div_cnt_n;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
   logic                 stop_cnt, stop_cnt_n;
   logic [DATA_W-1:0]    shift, shift_n;
   logic                 parity, parity_n;
   logic                 tx_n, tx_busy_n, tx_end_n;
   logic                 bit_done;

   assign bit_done = (div_cnt == DIV_CNT_W'(DIV_RATE - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shift    <= '0;
         parity   <= 1'b0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_end   <= 1'b0;
      end else begin
         state    <= state_n;
         div_cnt  <= div_cnt_n;
         bit_cnt  <= bit_cnt_n;
         stop_cnt <= stop_cnt_n;
         shift    <= shift_n;
         parity   <= parity_n;
         tx       <= tx_n;
         tx_busy  <= tx_busy_n;
         tx_end   <= tx_end_n;
      end
   end

   always_comb begin
      state_n    = state;
      div_cnt_n  = div_cnt;
      bit_cnt_n  = bit_cnt;
      stop_cnt_n = stop_cnt;
      shift_n    = shift;
      parity_n   = parity;
      tx_n       = tx;
      tx_busy_n  = tx_busy;
      tx_end_n   = 1'b0;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (tx_start) begin
               shift_n   = tx_data;
               parity_n  = (^tx_data) ^ (PARITY_ODD != 0);
               tx_n      = 1'b0;
               tx_busy_n = 1'b1;
               div_cnt_n = '0;
               state_n   = START;
            end
         end
         default: begin
            if (!bit_done) begin
               div_cnt_n = div_cnt + 1'b1;
            end else begin
               div_cnt_n = '0;
               case (state)
                  START: begin
                     tx_n      = shift[0];
                     bit_cnt_n = '0;
                     state_n   = DATA;
                  end
                  DATA: begin
                     if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        if (PARITY_EN != 0) begin
                           tx_n    = parity;
                           state_n = PARITY;
                        end else begin
                           tx_n       = 1'b1;
                           stop_cnt_n = 1'b0;
                           state_n    = STOP;
                        end
                     end else begin
                        shift_n   = shift >> 1;
                        tx_n      = shift_n[0];
                        bit_cnt_n = bit_cnt + 1'b1;
                     end
                  end
                  PARITY: begin
                     tx_n       = 1'b1;
                     stop_cnt_n = 1'b0;
                     state_n    = STOP;
                  end
                  STOP: begin
                     // tx_end lands in the same cycle the FSM is back in IDLE
                     if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        tx_n      = 1'b1;
                        tx_busy_n = 1'b0;
                        tx_end_n  = 1'b1;
                        state_n   = IDLE;
                     end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                     end
                  end
                  default: state_n = IDLE;
               endcase
            end
         end
      endcase
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a no-parity instance plus even/odd parity two-stop instances.
module tb_uart_tx_serializer;
   localparam int D = 4;
   localparam int M_NORM = 0, M_GLITCH = 1, M_CHAIN = 2, M_SCRAM = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_v [3];
   logic [7:0] data_v  [3];
   logic       tx_v    [3];
   logic       busy_v  [3];
   logic       end_v   [3];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.DIV_RATE(D), .DIV_CNT_W(3), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .tx_start(start_v[0]), .tx_data(data_v[0]),
      .tx_busy(busy_v[0]), .tx_end(end_v[0]), .tx(tx_v[0]));
   uart_tx_serializer #(.DIV_RATE(D), .DIV_CNT_W(3), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_e (
      .clk(clk), .reset(reset), .tx_start(start_v[1]), .tx_data(data_v[1]),
      .tx_busy(busy_v[1]), .tx_end(end_v[1]), .tx(tx_v[1]));
   uart_tx_serializer #(.DIV_RATE(D), .DIV_CNT_W(3), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
      .clk(clk), .reset(reset), .tx_start(start_v[2]), .tx_data(data_v[2]),
      .tx_busy(busy_v[2]), .tx_end(end_v[2]), .tx(tx_v[2]));

   // bits[i] is the i-th bit on the line (bit 0 = start bit)
   typedef struct {
      int          sel;
      logic [7:0]  data;
      logic [11:0] bits;
      int          nbits;
      int          mode;
      bit          pre;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [2:0] outs(input int s);
      return {tx_v[s], busy_v[s], end_v[s]};
   endfunction

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: tx/busy/end got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle 0 is the first start-bit cycle; cycle n is the tx_end cycle.
   task automatic run_vec(input vec_t v, input logic [7:0] nxt);
      int n;
      n = v.nbits * D;
      if (!v.pre) begin
         @(negedge clk);
         chk($sformatf("idle_before_%h", v.data), outs(v.sel), 3'b100);
         start_v[v.sel] = 1'b1;
         data_v[v.sel]  = v.data;
      end
      for (int k = 0; k <= n; k++) begin
         @(negedge clk);
         if (k < n)
            chk($sformatf("u%0d_%h_c%0d", v.sel, v.data, k), outs(v.sel), {v.bits[k / D], 2'b10});
         else
            chk($sformatf("u%0d_%h_end", v.sel, v.data), outs(v.sel), 3'b101);
         start_v[v.sel] = 1'b0;
         if (v.mode == M_SCRAM) data_v[v.sel] = 8'($urandom);
         if (v.mode == M_GLITCH && k == 3 * D + 1) begin
            start_v[v.sel] = 1'b1;
            data_v[v.sel]  = 8'hFF;
         end
         if (v.mode == M_CHAIN && k == n) begin
            start_v[v.sel] = 1'b1;
            data_v[v.sel]  = nxt;
         end
      end
   endtask

   initial begin
      vec_t v3c;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         data_v[i]  = 8'h00;
      end
      tbl[0] = '{0, 8'h55, 12'b00_1_01010101_0, 10, M_NORM,   1'b0};
      tbl[1] = '{0, 8'hA5, 12'b00_1_10100101_0, 10, M_GLITCH, 1'b0};
      tbl[2] = '{0, 8'h0F, 12'b00_1_00001111_0, 10, M_CHAIN,  1'b0};
      tbl[3] = '{0, 8'hF0, 12'b00_1_11110000_0, 10, M_NORM,   1'b1};
      tbl[4] = '{0, 8'h81, 12'b00_1_10000001_0, 10, M_SCRAM,  1'b0};
      tbl[5] = '{1, 8'h07, 12'b11_1_00000111_0, 12, M_NORM,   1'b0};
      tbl[6] = '{2, 8'h07, 12'b11_0_00000111_0, 12, M_NORM,   1'b0};
      tbl[7] = '{1, 8'h03, 12'b11_0_00000011_0, 12, M_NORM,   1'b0};
      tbl[8] = '{2, 8'h03, 12'b11_1_00000011_0, 12, M_NORM,   1'b0};
      v3c    = '{0, 8'h3C, 12'b00_1_00111100_0, 10, M_NORM,   1'b0};

      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) chk($sformatf("reset_u%0d", s), outs(s), 3'b100);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(tbl[i], (i < 8) ? tbl[i + 1].data : 8'h00);

      // reset in the middle of data bit 3 of 8'hC3
      @(negedge clk);
      start_v[0] = 1'b1;
      data_v[0]  = 8'hC3;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4 * D + 1) @(negedge clk);
      chk("rst_pre_bit3", outs(0), 3'b010);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_next", outs(0), 3'b100);
      for (int k = 0; k < 12 * D; k++) begin
         @(negedge clk);
         chk($sformatf("rst_quiet_c%0d", k), outs(0), 3'b100);
      end
      run_vec(v3c, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
